mem_port_arbiter: RTL and testbench

//  Shares one 32-bit memory port between instruction fetch (IF, requester 0) and load/store (LS, requester 1).

---
 rtl/mem_port_arbiter.sv | 107 ++++++++++
 tb/tb_mem_port_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and load/store; optional access timeout under MEM_TIMEOUT_EN
module mem_port_arbiter #(
  parameter int DATA_PRIO      = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic [31:0] ls_addr,
  input  logic        ls_we,
  input  logic [3:0]  ls_be,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        sel,
  output logic        busy,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state;
  logic last_owner, win_ls, tmo, done;
  logic [31:0] cap;
`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt;
  assign tmo = !mem_ready && (cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif
  // LS wins a tie under fixed priority or when IF owned the port last
  assign win_ls = ls_req && (!if_req || (DATA_PRIO != 0) || !last_owner);
  assign if_gnt = (state == IDLE) && if_req && !win_ls;
  assign ls_gnt = (state == IDLE) && win_ls;
  assign busy   = (state != IDLE);
  assign done   = mem_ready || tmo;
  assign cap    = mem_ready ? mem_rdata : 32'd0;
  // grant, hold the access until completion or abort, then one response cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      sel        <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      if_rvalid  <= 1'b0;
      ls_rvalid  <= 1'b0;
      if_rdata   <= '0;
      ls_rdata   <= '0;
      err        <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (if_req || ls_req) begin
          mem_addr   <= win_ls ? ls_addr : if_addr;
          mem_we     <= win_ls && ls_we;
          mem_be     <= win_ls ? ls_be : 4'hF;
          mem_wdata  <= win_ls ? ls_wdata : 32'd0;
          sel        <= win_ls;
          last_owner <= win_ls;
          mem_req    <= 1'b1;
          state      <= ACCESS;
`ifdef MEM_TIMEOUT_EN
          cnt        <= '0;
`endif
        end
        ACCESS: begin
`ifdef MEM_TIMEOUT_EN
          cnt <= cnt + 8'd1;
`endif
          if (done) begin
            mem_req   <= 1'b0;
            if_rvalid <= !sel;
            ls_rvalid <= sel;
            err       <= tmo;
            state     <= RESP;
            if (sel) ls_rdata <= cap;
            else     if_rdata <= cap;
          end
        end
        RESP: begin
          if_rvalid <= 1'b0;
          ls_rvalid <= 1'b0;
          err       <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random traffic into a fixed-priority and a round-robin arbiter, checked against a transaction model
module tb_mem_port_arbiter;
`ifdef MEM_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  logic        if_req[2], ls_req[2], ls_we[2], mem_ready[2];
  logic [31:0] if_addr[2], ls_addr[2], ls_wdata[2], mem_rdata[2];
  logic [3:0]  ls_be[2];
  logic        if_gnt[2], if_rvalid[2], ls_gnt[2], ls_rvalid[2], mem_req[2], mem_we[2], sel[2], busy[2], err[2];
  logic [31:0] if_rdata[2], ls_rdata[2], mem_addr[2], mem_wdata[2];
  logic [3:0]  mem_be[2];
  mem_port_arbiter #(.DATA_PRIO(1), .TIMEOUT_CYCLES(TMO)) u_prio (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]), .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
    .ls_req(ls_req[0]), .ls_addr(ls_addr[0]), .ls_we(ls_we[0]), .ls_be(ls_be[0]), .ls_wdata(ls_wdata[0]),
    .ls_gnt(ls_gnt[0]), .ls_rvalid(ls_rvalid[0]), .ls_rdata(ls_rdata[0]),
    .mem_req(mem_req[0]), .mem_addr(mem_addr[0]), .mem_we(mem_we[0]), .mem_be(mem_be[0]), .mem_wdata(mem_wdata[0]),
    .mem_ready(mem_ready[0]), .mem_rdata(mem_rdata[0]), .sel(sel[0]), .busy(busy[0]), .err(err[0])
  );
  mem_port_arbiter #(.DATA_PRIO(0), .TIMEOUT_CYCLES(TMO)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]), .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
    .ls_req(ls_req[1]), .ls_addr(ls_addr[1]), .ls_we(ls_we[1]), .ls_be(ls_be[1]), .ls_wdata(ls_wdata[1]),
    .ls_gnt(ls_gnt[1]), .ls_rvalid(ls_rvalid[1]), .ls_rdata(ls_rdata[1]),
    .mem_req(mem_req[1]), .mem_addr(mem_addr[1]), .mem_we(mem_we[1]), .mem_be(mem_be[1]), .mem_wdata(mem_wdata[1]),
    .mem_ready(mem_ready[1]), .mem_rdata(mem_rdata[1]), .sel(sel[1]), .busy(busy[1]), .err(err[1])
  );
  int errors = 0, checks = 0;
  // transaction-level reference: phase 0 idle, 1 memory access in flight, 2 response cycle
  int          ph[2], waited[2];
  bit          own[2], last[2], m_we[2], m_err[2], if_pend[2], ls_pend[2];
  logic [31:0] m_addr[2], m_wd[2], m_ird[2], m_lrd[2];
  logic [3:0]  m_be[2];
  task automatic check(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s[%0d] @%0t: got %h want %h", tag, i, $time, obs, exp);
    end
  endtask
  function automatic bit ls_wins(input int i);
    if (!ls_req[i]) return 1'b0;
    if (!if_req[i]) return 1'b1;
    return (i == 0) ? 1'b1 : !last[i];
  endfunction
  task automatic model_reset(input int i);
    ph[i] = 0; waited[i] = 0; own[i] = 0; last[i] = 1; m_we[i] = 0; m_err[i] = 0;
    m_addr[i] = 0; m_wd[i] = 0; m_ird[i] = 0; m_lrd[i] = 0; m_be[i] = 0;
  endtask
  task automatic check_all(input int i);
    bit g, wl;
    g  = (ph[i] == 0) && (if_req[i] || ls_req[i]);
    wl = ls_wins(i);
    check("if_gnt", i, 32'(if_gnt[i]), 32'(g && !wl));
    check("ls_gnt", i, 32'(ls_gnt[i]), 32'(g && wl));
    check("mem_req", i, 32'(mem_req[i]), 32'(ph[i] == 1));
    check("busy", i, 32'(busy[i]), 32'(ph[i] != 0));
    check("sel", i, 32'(sel[i]), 32'(own[i]));
    check("mem_addr", i, mem_addr[i], m_addr[i]);
    check("mem_we", i, 32'(mem_we[i]), 32'(m_we[i]));
    check("mem_be", i, 32'(mem_be[i]), 32'(m_be[i]));
    check("mem_wdata", i, mem_wdata[i], m_wd[i]);
    check("if_rvalid", i, 32'(if_rvalid[i]), 32'(ph[i] == 2 && !own[i]));
    check("ls_rvalid", i, 32'(ls_rvalid[i]), 32'(ph[i] == 2 && own[i]));
    check("if_rdata", i, if_rdata[i], m_ird[i]);
    check("ls_rdata", i, ls_rdata[i], m_lrd[i]);
    check("err", i, 32'(err[i]), 32'(ph[i] == 2 && m_err[i]));
  endtask
  task automatic model_step(input int i);
    bit wl, fin;
    logic [31:0] d;
    if (ph[i] == 0) begin
      if (if_req[i] || ls_req[i]) begin
        wl = ls_wins(i);
        own[i] = wl; last[i] = wl; ph[i] = 1; waited[i] = 0;
        m_addr[i] = wl ? ls_addr[i] : if_addr[i];
        m_we[i]   = wl && ls_we[i];
        m_be[i]   = wl ? ls_be[i] : 4'hF;
        m_wd[i]   = wl ? ls_wdata[i] : 32'd0;
        if (wl) ls_pend[i] = 0; else if_pend[i] = 0;
      end
    end else if (ph[i] == 1) begin
      fin = mem_ready[i];
      d = mem_ready[i] ? mem_rdata[i] : 32'd0;
      m_err[i] = 0;
`ifdef MEM_TIMEOUT_EN
      if (!fin) begin
        waited[i]++;
        if (waited[i] == TMO) begin fin = 1; m_err[i] = 1; end
      end
`endif
      if (fin) begin
        ph[i] = 2;
        if (own[i]) m_lrd[i] = d; else m_ird[i] = d;
      end
    end else ph[i] = 0;
  endtask
  task automatic drive(input int i, input bit stall);
    if (!if_pend[i] && $urandom_range(0, 1) == 1) begin
      if_pend[i] = 1;
      if_addr[i] = $urandom & 32'hFFFF_FFFC;
    end
    if (!ls_pend[i] && $urandom_range(0, 1) == 1) begin
      ls_pend[i]  = 1;
      ls_addr[i]  = $urandom;
      ls_we[i]    = 1'($urandom_range(0, 1));
      ls_be[i]    = 4'($urandom);
      ls_wdata[i] = $urandom;
    end
    if_req[i]    = if_pend[i];
    ls_req[i]    = ls_pend[i];
    mem_ready[i] = !stall && ($urandom_range(0, 2) == 0);
    mem_rdata[i] = $urandom;
  endtask
  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if_req[i] = 0; ls_req[i] = 0; ls_we[i] = 0; mem_ready[i] = 1; if_pend[i] = 0; ls_pend[i] = 0;
      if_addr[i] = 0; ls_addr[i] = 0; ls_wdata[i] = 0; ls_be[i] = 0; mem_rdata[i] = 32'hDEAD_BEEF;
      model_reset(i);
    end
    #2;
    for (int i = 0; i < 2; i++) check_all(i);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 900) begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
          if_pend[i] = 0; ls_pend[i] = 0; if_req[i] = 0; ls_req[i] = 0;
          model_reset(i);
        end
        #1;
        for (int i = 0; i < 2; i++) check_all(i);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) check_all(i);
        rst_n = 1'b1;
      end else begin
        for (int i = 0; i < 2; i++) drive(i, cyc >= 780 && cyc < 930);
        #1;
        for (int i = 0; i < 2; i++) begin
          check_all(i);
          model_step(i);
        end
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
